// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings as presented on op_i
//   - FSM state encoding
//   - position of the MDU stall request on the CTRL stall bus
//   - small decode helpers for op_i
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // Bit of the CTRL stall bus driven by stallreq_o (EX stage).
  localparam int STALL_EX_IDX = 2;

  // Bit 0 of the op code distinguishes unsigned (1) from signed (0).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 of the op code selects divide.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign correction for a pair of WIDTH-bit words.
// Used twice by mdu_iter: to take absolute values of the operands, and to
// apply the result sign on the way into DONE.
//   hi, lo         : input words
//   neg_hi, neg_lo : negate request per word (independent mode)
//   joint          : 1 = treat {hi,lo} as one 2*WIDTH value, negated when
//                    neg_lo is set (product); 0 = negate words separately
//   hi_fix, lo_fix : corrected words
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic             joint,
  output logic [WIDTH-1:0] hi_fix,
  output logic [WIDTH-1:0] lo_fix
);

  logic [2*WIDTH-1:0] wide_neg;

  assign wide_neg = -{hi, lo};

  always_comb begin
    hi_fix = hi;
    lo_fix = lo;
    if (joint) begin
      if (neg_lo) {hi_fix, lo_fix} = wide_neg;
    end else begin
      if (neg_hi) hi_fix = -hi;
      if (neg_lo) lo_fix = -lo;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage, producing HI:LO.
//   clk, rst        : clock, asynchronous active-high reset
//   start_i, op_i   : request and op (MULT/MULTU/DIV/DIVU)
//   src_a_i/src_b_i : multiplicand/dividend, multiplier/divisor
//   cancel_i        : flush, abandons any operation or pending result
//   result_ack_i    : consumer took the result
//   busy_o          : iterating (MUL or DIV)
//   stallreq_o      : busy, or a start accepted this cycle
//   result_valid_o  : hi_o/lo_o/div_by_zero_o valid (DONE)
//   hi_o, lo_o      : product halves, or remainder/quotient
//   div_by_zero_o   : divide with zero divisor
// The core works on magnitudes; signs are stripped on accept and
// re-applied on the edge that enters DONE.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit MUL_ITER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             cancel_i,
  input  logic             result_ack_i,
  output logic             busy_o,
  output logic             stallreq_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  mdu_state_e state, state_next, start_target;

  logic [CW-1:0]    cnt;
  logic             is_div, neg_a, neg_b;
  logic [WIDTH-1:0] mcand, rem, quo;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic             dbz_res;

  logic             accept, in_div, in_neg_a, in_neg_b, in_dbz;
  logic             direct_mul, iterating, iter_last;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [2*WIDTH-1:0] fast_prod;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] fix_in_hi, fix_in_lo, fix_hi, fix_lo;
  logic             fix_neg_hi, fix_neg_lo, fix_joint;

  assign in_div   = op_is_div(op_i);
  assign in_neg_a = op_is_signed(op_i) & src_a_i[WIDTH-1];
  assign in_neg_b = op_is_signed(op_i) & src_b_i[WIDTH-1];
  assign in_dbz   = in_div & (src_b_i == '0);

  // Cancel always wins over a coincident start.
  assign accept = start_i & ~cancel_i &
                  ((state == ST_IDLE) | ((state == ST_DONE) & result_ack_i));

  assign direct_mul = accept & ~in_div & ~MUL_ITER;
  assign iterating  = (state == ST_MUL) | (state == ST_DIV);
  assign iter_last  = iterating & (cnt == LAST);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_ops (
    .hi(src_a_i), .lo(src_b_i), .neg_hi(in_neg_a), .neg_lo(in_neg_b),
    .joint(1'b0), .hi_fix(a_abs), .lo_fix(b_abs)
  );

  generate
    if (MUL_ITER) begin : g_no_fast
      assign fast_prod = '0;
    end else begin : g_fast
      assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
    end
  endgenerate

  // Shift-add step: {rem,quo} is the running product, quo's LSB is the
  // current multiplier bit; the carry of the add shifts into rem's MSB.
  assign mul_sum = {1'b0, rem} + (quo[0] ? {1'b0, mcand} : '0);

  // Restoring step: rem < divisor holds, so bit WIDTH of the difference is
  // a clean borrow flag.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand};
  assign div_ok    = ~div_diff[WIDTH];

  always_comb begin
    fix_in_hi  = rem;
    fix_in_lo  = quo;
    fix_joint  = ~is_div;
    fix_neg_lo = neg_a ^ neg_b;   // product or quotient sign
    fix_neg_hi = neg_a;           // remainder follows the dividend
    if (direct_mul) begin
      {fix_in_hi, fix_in_lo} = fast_prod;
      fix_joint  = 1'b1;
      fix_neg_lo = in_neg_a ^ in_neg_b;
      fix_neg_hi = 1'b0;
    end
  end

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_res (
    .hi(fix_in_hi), .lo(fix_in_lo), .neg_hi(fix_neg_hi), .neg_lo(fix_neg_lo),
    .joint(fix_joint), .hi_fix(fix_hi), .lo_fix(fix_lo)
  );

  always_comb begin
    start_target = ST_DONE;
    if (!in_dbz) begin
      if (in_div)        start_target = ST_DIV;
      else if (MUL_ITER) start_target = ST_MUL;
    end

    state_next = state;
    if (cancel_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_next = start_target;
        ST_MUL,
        ST_DIV:  if (iter_last) state_next = ST_DONE;
        ST_DONE: if (result_ack_i) state_next = accept ? start_target : ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      mcand   <= '0;
      rem     <= '0;
      quo     <= '0;
      hi_res  <= '0;
      lo_res  <= '0;
      dbz_res <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        is_div <= in_div;
        neg_a  <= in_neg_a;
        neg_b  <= in_neg_b;
        mcand  <= in_div ? b_abs : a_abs;
        quo    <= in_div ? a_abs : b_abs;
        rem    <= '0;
      end else if (iterating && !iter_last) begin
        cnt <= cnt + 1'b1;
        if (state == ST_MUL) begin
          {rem, quo} <= {mul_sum, quo[WIDTH-1:1]};
        end else begin
          rem <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], div_ok};
        end
      end

      if (accept && in_dbz) begin
        hi_res  <= src_a_i;
        lo_res  <= '1;
        dbz_res <= 1'b1;
      end else if (direct_mul || iter_last) begin
        hi_res  <= fix_hi;
        lo_res  <= fix_lo;
        dbz_res <= 1'b0;
      end
    end
  end

  assign busy_o         = iterating;
  assign stallreq_o     = iterating | accept;
  assign result_valid_o = (state == ST_DONE);
  assign hi_o           = result_valid_o ? hi_res : '0;
  assign lo_o           = result_valid_o ? lo_res : '0;
  assign div_by_zero_o  = result_valid_o & dbz_res;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: an iterative instance (MUL_ITER=1) and a
// single-cycle-multiply instance (MUL_ITER=0) share operand/cancel/ack
// inputs and have separate starts. Expected results come from a behavioural
// model, are queued at start and popped when result_valid_o rises.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_m = 1'b0, start_d = 1'b0, cancel = 1'b0, ack = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic sel = 1'b0;

  logic busy_m, stall_m, valid_m, dbz_m, busy_d, stall_d, valid_d, dbz_d;
  logic [W-1:0] hi_m, lo_m, hi_d, lo_d;
  logic obs_busy, obs_stall, obs_valid, obs_dbz;
  logic [W-1:0] obs_hi, obs_lo;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;
  res_t exp_q[$];

  logic [1:0]   r_op;
  logic [W-1:0] r_a, r_b;
  logic         r_sel, flag;
  int           r_lat;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W), .MUL_ITER(1'b1)) dut (
    .clk(clk), .rst(rst), .start_i(start_m), .op_i(op), .src_a_i(a), .src_b_i(b),
    .cancel_i(cancel), .result_ack_i(ack), .busy_o(busy_m), .stallreq_o(stall_m),
    .result_valid_o(valid_m), .hi_o(hi_m), .lo_o(lo_m), .div_by_zero_o(dbz_m)
  );

  mdu_iter #(.WIDTH(W), .MUL_ITER(1'b0)) dut_fast (
    .clk(clk), .rst(rst), .start_i(start_d), .op_i(op), .src_a_i(a), .src_b_i(b),
    .cancel_i(cancel), .result_ack_i(ack), .busy_o(busy_d), .stallreq_o(stall_d),
    .result_valid_o(valid_d), .hi_o(hi_d), .lo_o(lo_d), .div_by_zero_o(dbz_d)
  );

  assign obs_busy  = sel ? busy_d  : busy_m;
  assign obs_stall = sel ? stall_d : stall_m;
  assign obs_valid = sel ? valid_d : valid_m;
  assign obs_dbz   = sel ? dbz_d   : dbz_m;
  assign obs_hi    = sel ? hi_d    : hi_m;
  assign obs_lo    = sel ? lo_d    : lo_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural reference using the simulator's 64-bit arithmetic.
  function automatic res_t model(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    res_t r;
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    r = '0;
    if (o[1] && vb == '0) begin
      r.hi = va; r.lo = '1; r.dbz = 1'b1;
    end else begin
      case (o)
        MDU_MULT:  begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
        MDU_MULTU: begin p = {32'd0, va} * {32'd0, vb}; r.hi = p[63:32]; r.lo = p[31:0]; end
        MDU_DIV:   begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
        default:   begin r.lo = va / vb; r.hi = va % vb; end
      endcase
    end
    return r;
  endfunction

  // One transaction. exp_lat counts rising edges after the accepting edge
  // before result_valid_o is seen (0 = valid straight from the accept edge).
  task automatic do_op(input logic s, input logic [1:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input int exp_lat, input int hold,
                       input logic keep, input logic ack_in);
    int lat;
    logic stall_ok, stable;
    logic [W-1:0] h0, l0;
    res_t e;
    @(negedge clk);
    sel = s; op = o; a = va; b = vb; ack = ack_in;
    if (s) start_d = 1'b1; else start_m = 1'b1;
    exp_q.push_back(model(o, va, vb));
    #1 check("stall_accept", 64'(obs_stall), 64'd1);
    @(posedge clk);
    #1;
    start_m = 1'b0; start_d = 1'b0; ack = 1'b0;
    lat = 0; stall_ok = 1'b1;
    while (!obs_valid && lat < 100) begin
      if (!(obs_stall && obs_busy)) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("stall_busy", 64'(stall_ok), 64'd1);
    check("stall_done", 64'(obs_stall), 64'd0);
    check("sb_pending", 64'(exp_q.size()), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("hi", 64'(obs_hi), 64'(e.hi));
    check("lo", 64'(obs_lo), 64'(e.lo));
    check("dbz", 64'(obs_dbz), 64'(e.dbz));
    $display("dut%0d op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0b lat=%0d",
             s, o, va, vb, obs_hi, obs_lo, obs_dbz, lat);
    h0 = obs_hi; l0 = obs_lo; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (obs_hi !== h0 || obs_lo !== l0 || obs_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", 64'(stable), 64'd1);
    if (!keep) begin
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      check("ack_release", 64'(obs_valid), 64'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_stall", 64'(stall_m), 64'd0);
    check("rst_valid", 64'({valid_m, valid_d}), 64'd0);
    check("rst_hilo", {hi_m, lo_m}, 64'd0);
    check("rst_dbz", 64'(dbz_m), 64'd0);
    rst = 1'b0;

    do_op(1'b0, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, 1'b0, 1'b0);
    do_op(1'b0, MDU_MULT,  32'hFFFFFFFD, 32'd7,        33, 0, 1'b0, 1'b0);
    do_op(1'b1, MDU_MULT,  32'hFFFFFFFD, 32'd7,        0,  0, 1'b0, 1'b0);
    do_op(1'b0, MDU_DIV,   32'hFFFFFFF9, 32'd2,        33, 0, 1'b0, 1'b0);
    do_op(1'b0, MDU_DIVU,  32'd100,      32'd7,        33, 0, 1'b0, 1'b0);
    do_op(1'b0, MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 0, 1'b0, 1'b0);
    do_op(1'b0, MDU_DIV,   32'h12345678, 32'd0,        0,  0, 1'b0, 1'b0);

    // Cancel at iteration 10 of a DIVU
    @(negedge clk);
    sel = 1'b0; op = MDU_DIVU; a = 32'd1000; b = 32'd7; start_m = 1'b1;
    @(posedge clk);
    #1 start_m = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    check("cancel_busy", 64'(busy_m), 64'd0);
    check("cancel_valid", 64'(valid_m), 64'd0);
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (valid_m || busy_m) flag = 1'b1;
    end
    check("cancel_no_result", 64'(flag), 64'd0);

    // Cancel and start together: start dropped
    @(negedge clk);
    op = MDU_MULTU; a = 32'd3; b = 32'd5; start_m = 1'b1; cancel = 1'b1;
    #1 check("cancel_start_stall", 64'(stall_m), 64'd0);
    @(posedge clk);
    #1 start_m = 1'b0; cancel = 1'b0;
    check("cancel_start_idle", 64'({busy_m, valid_m}), 64'd0);

    do_op(1'b0, MDU_MULTU, 32'd3, 32'd5, 33, 0, 1'b0, 1'b0);

    // Result held without ack, then ack + start back-to-back
    do_op(1'b0, MDU_DIVU,  32'd1000, 32'd3, 33, 5, 1'b1, 1'b0);
    do_op(1'b0, MDU_MULTU, 32'd2,    32'd2, 33, 0, 1'b0, 1'b1);

    // Mixed random operations on both instances
    for (int k = 0; k < 8; k++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_a   = $urandom;
      r_b   = (k % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      r_sel = k[0];
      r_lat = ((r_op[1] && r_b == '0) || (r_sel && !r_op[1])) ? 0 : 33;
      do_op(r_sel, r_op, r_a, r_b, r_lat, 0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    sel = 1'b0; op = MDU_DIV; a = 32'd12345; b = 32'd11; start_m = 1'b1;
    @(posedge clk);
    #1 start_m = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'({busy_m, stall_m}), 64'd0);
    check("rst_mid_valid", 64'({valid_m, dbz_m}), 64'd0);
    check("rst_mid_hilo", {hi_m, lo_m}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage.
- Generalises the fixed 32-bit HILO producer: adds configurable WIDTH, optional single-cycle multiply, cancel/flush, and a valid/ack result handshake.
- Produces a 2*WIDTH HI:LO result for MULT/MULTU/DIV/DIVU.
- Raises a stall request to CTRL while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
MUL_ITER, 1, 1 = radix-2 shift-add multiply (WIDTH iterations); 0 = single-cycle multiply registered into DONE.

Ports:
clk  in  1  clock; one clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start_i  in  1  request a new operation.
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
src_a_i  in  WIDTH  multiplicand / dividend.
src_b_i  in  WIDTH  multiplier / divisor.
cancel_i  in  1  pipeline flush; abort the current operation.
result_ack_i  in  1  consumer has taken the result (HILO write).
busy_o  out  1  state is MUL or DIV.
stallreq_o  out  1  to CTRL: busy_o OR (start_i accepted this cycle).
result_valid_o  out  1  HI/LO/flag valid (state DONE).
hi_o  out  WIDTH  product high half, or remainder.
lo_o  out  WIDTH  product low half, or quotient.
div_by_zero_o  out  1  valid with result; DIV/DIVU with src_b_i == 0.

Behaviour:
- Reset (async): state IDLE, counter 0, all outputs 0; an in-flight operation is discarded.
- States: IDLE, MUL, DIV, DONE.
- Counter width is clog2(WIDTH+1).
- Accept rule: start_i is accepted in IDLE, or in DONE with result_ack_i high (back-to-back). On acceptance, operands and op are latched.
- Operand preparation: for signed ops, absolute values are taken and the result sign is recorded. The core always computes unsigned.
- Ignored cases: start_i in MUL/DIV is ignored; start_i in DONE without ack is ignored.
- MUL (MUL_ITER=1): one shift-add per cycle for WIDTH cycles, then DONE.
- MUL with MUL_ITER=0: the accept edge goes straight to DONE with the product registered; result_valid_o is high the next cycle.
- DIV: restoring division, one quotient bit per cycle for WIDTH cycles, then DONE.
- Latency (iterative): result_valid_o is high starting WIDTH+1 rising edges after the accepting edge (33 for WIDTH=32).
- Sign fix on the transition into DONE:
  - product negated if operand signs differ;
  - quotient sign = sign(a) XOR sign(b);
  - remainder sign = sign(a).
- Overflow: signed MIN / -1 gives quotient MIN, remainder 0, no flag.
- Divide by zero: bypasses the iterations and enters DONE after 1 edge. Result is lo = all ones, hi = dividend unchanged, div_by_zero_o = 1.
- DONE: outputs are held stable until result_ack_i. Ack without start → IDLE. Ack with start → new operation.
- cancel_i in any state: IDLE on the next edge, result_valid_o low, no result emitted.
- cancel_i with start_i in the same cycle: cancel wins and start is dropped.
- stallreq_o is combinational from state and start_i; it is low in IDLE without start, and low in DONE.
- Outputs hi_o/lo_o/div_by_zero_o are 0 whenever result_valid_o is low.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_MULT/MULTU/DIV/DIVU;
  - state encoding;
  - the stall bus index that stallreq_o maps onto.
- One natural sub-module, mdu_sign_fix: combinational abs-value pre-processing and result sign correction, instantiated once for operands and once for results.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Valid exactly 33 edges after the accepting edge; stallreq_o high for those cycles.
- MULT 0xFFFFFFFD (−3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with MUL_ITER=0 → same values, valid after 1 edge.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV 0x12345678 / 0 → lo=0xFFFFFFFF, hi=0x12345678, div_by_zero_o=1, valid after 1 edge.
- Start DIVU, assert cancel_i at iteration 10 → busy_o low next cycle, no valid. Also: cancel+start in the same cycle → stays IDLE. Fresh MULTU 3×5 afterwards → lo=15.
- Hold result_ack_i low for 5 cycles in DONE → outputs stable. Then ack+start MULTU 2×2 in the same cycle → new op accepted, lo=4. Assert rst mid-DIV → all outputs 0 immediately.
